// File: rtl/rx_frame_sync.sv
// Byte-stream frame synchroniser: hunts for a 0x55 preamble and 0xD5 delimiter,
// reads a 16-bit little-endian length, re-emits a 3-byte header followed by the
// payload, and pads a stalled frame with 0x00 so the consumer always gets L bytes.
module rx_frame_sync #(
    parameter int unsigned SYNC_LEN = 2,
    parameter logic [15:0] MAX_LEN  = 16'd1500,
    parameter logic [15:0] TIMEOUT  = 16'd4096
) (
    input  logic        i_rx_clk,
    input  logic        i_rx_rst,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic [31:0] o_rx_data,
    output logic        o_rx_data_valid,
    output logic        o_rx_sof,
    output logic        o_frame_done,
    output logic        o_len_err,
    output logic        o_timeout_err,
    output logic        o_ovr_err,
    output logic [15:0] o_frame_cnt
);

    typedef enum logic [2:0] {
        StHunt,
        StLenLo,
        StLenHi,
        StHdr,
        StPayload,
        StPad
    } state_e;

    localparam logic [15:0] SyncLen = 16'(SYNC_LEN);

    state_e      state_q, state_d;
    logic [15:0] sync_q, sync_d;
    logic [15:0] len_q, len_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] idle_q, idle_d;
    logic [1:0]  hdr_q, hdr_d;
    logic [1:0]  pad_q, pad_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        sof_q, sof_d;
    logic        done_q, done_d;
    logic        len_err_q, len_err_d;
    logic        to_err_q, to_err_d;
    logic        ovr_q, ovr_d;
    logic [15:0] cnt_q, cnt_d;

    logic [15:0] len_full;
    logic        len_ok;
    logic        timeout_hit;

    // State and output registers; outputs are registered so every pulse is glitch-free.
    always_ff @(posedge i_rx_clk) begin
        if (i_rx_rst) begin
            state_q   <= StHunt;
            sync_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            idle_q    <= '0;
            hdr_q     <= '0;
            pad_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            sof_q     <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            to_err_q  <= 1'b0;
            ovr_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            idle_q    <= idle_d;
            hdr_q     <= hdr_d;
            pad_q     <= pad_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            sof_q     <= sof_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
            to_err_q  <= to_err_d;
            ovr_q     <= ovr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic: parse preamble/length, emit header, forward or pad payload.
    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        len_d     = len_q;
        rem_d     = rem_q;
        idle_d    = '0;  // idle count restarts on any byte or state change
        hdr_d     = hdr_q;
        pad_d     = pad_q;
        data_d    = data_q;  // data holds between strobes
        valid_d   = 1'b0;
        sof_d     = 1'b0;
        done_d    = 1'b0;
        len_err_d = 1'b0;
        to_err_d  = 1'b0;
        ovr_d     = 1'b0;
        cnt_d     = cnt_q;

        len_full    = {i_byte, len_q[7:0]};
        len_ok      = (len_full != 16'd0) && (len_full <= MAX_LEN);
        // Fires on the cycle the idle count would reach TIMEOUT; a byte that cycle wins.
        timeout_hit = ({1'b0, idle_q} + 17'd1) >= {1'b0, TIMEOUT};

        case (state_q)
            StHunt: begin
                if (i_byte_valid) begin
                    if (i_byte == 8'h55) begin
                        if (sync_q < SyncLen) begin
                            sync_d = sync_q + 16'd1;
                        end
                    end else if (i_byte == 8'hD5 && sync_q >= SyncLen) begin
                        sync_d  = '0;
                        state_d = StLenLo;
                    end else begin
                        sync_d = '0;
                    end
                end
            end
            StLenLo: begin
                if (i_byte_valid) begin
                    len_d[7:0] = i_byte;
                    state_d    = StLenHi;
                end else if (timeout_hit) begin
                    to_err_d = 1'b1;
                    state_d  = StHunt;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            StLenHi: begin
                if (i_byte_valid) begin
                    len_d = len_full;
                    if (len_ok) begin
                        // First header byte goes out with the same latency as payload.
                        state_d = StHdr;
                        rem_d   = len_full;
                        hdr_d   = 2'd1;
                        data_d  = 8'h55;
                        valid_d = 1'b1;
                        sof_d   = 1'b1;
                    end else begin
                        len_err_d = 1'b1;
                        state_d   = StHunt;
                    end
                end else if (timeout_hit) begin
                    to_err_d = 1'b1;
                    state_d  = StHunt;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            StHdr: begin
                // Output slot is busy with the header, so any input byte is lost.
                ovr_d   = i_byte_valid;
                valid_d = 1'b1;
                if (hdr_q == 2'd1) begin
                    data_d = len_q[7:0];
                    hdr_d  = 2'd2;
                end else begin
                    data_d  = len_q[15:8];
                    hdr_d   = 2'd0;
                    state_d = StPayload;
                end
            end
            StPayload: begin
                if (i_byte_valid) begin
                    data_d  = i_byte;
                    valid_d = 1'b1;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = StHunt;
                    end
                end else if (timeout_hit) begin
                    to_err_d = 1'b1;
                    pad_d    = 2'd0;
                    state_d  = StPad;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            StPad: begin
                // One zero byte every fourth cycle until the promised length is met.
                if (pad_q == 2'd3) begin
                    pad_d   = 2'd0;
                    data_d  = 8'h00;
                    valid_d = 1'b1;
                    rem_d   = rem_q - 16'd1;
                    if (rem_q == 16'd1) begin
                        done_d  = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = StHunt;
                    end
                end else begin
                    pad_d = pad_q + 2'd1;
                end
            end
            default: begin
                state_d = StHunt;
            end
        endcase
    end

    assign o_rx_data       = {24'd0, data_q};
    assign o_rx_data_valid = valid_q;
    assign o_rx_sof        = sof_q;
    assign o_frame_done    = done_q;
    assign o_len_err       = len_err_q;
    assign o_timeout_err   = to_err_q;
    assign o_ovr_err       = ovr_q;
    assign o_frame_cnt     = cnt_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Bench for rx_frame_sync: drives byte streams, logs every output event with its
// clock edge, and compares against a frame-level reference model of the byte protocol.
module tb_rx_frame_sync;

    localparam int SYNC   = 2;
    localparam int MAXL   = 20;
    localparam int TMO    = 40;
    localparam int SETTLE = TMO + 4 * MAXL + 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_byte = 8'h00;
    logic        i_byte_valid = 1'b0;
    logic [31:0] o_rx_data;
    logic        o_rx_data_valid, o_rx_sof, o_frame_done;
    logic        o_len_err, o_timeout_err, o_ovr_err;
    logic [15:0] o_frame_cnt;

    rx_frame_sync #(
        .SYNC_LEN(SYNC),
        .MAX_LEN (16'(MAXL)),
        .TIMEOUT (16'(TMO))
    ) dut (
        .i_rx_clk       (clk),
        .i_rx_rst       (rst),
        .i_byte         (i_byte),
        .i_byte_valid   (i_byte_valid),
        .o_rx_data      (o_rx_data),
        .o_rx_data_valid(o_rx_data_valid),
        .o_rx_sof       (o_rx_sof),
        .o_frame_done   (o_frame_done),
        .o_len_err      (o_len_err),
        .o_timeout_err  (o_timeout_err),
        .o_ovr_err      (o_ovr_err),
        .o_frame_cnt    (o_frame_cnt)
    );

    always #5 clk = ~clk;

    // Event word: {edge, kind, 2'b0, sof, done, data}. Kinds: 0 data, 1 len_err,
    // 2 timeout, 3 overrun, 4 sof/done without valid, 5 data not held, 6 upper bits set.
    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    int          stim_e[$];
    logic [7:0]  stim_b[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          m_sync = 0;
    int          m_frames = 0;
    logic [7:0]  last_data = 8'h00;

    function automatic logic [39:0] mk(int e, int kind, logic [7:0] d, logic sof, logic done);
        return {e[23:0], kind[3:0], 2'b00, sof, done, d};
    endfunction

    task automatic push_exp(input logic [39:0] v);
        int i = 0;
        while (i < exp_q.size() && exp_q[i] <= v) i++;
        exp_q.insert(i, v);
    endtask

    // One clock: wait for the edge, then log whatever the DUT produced at it.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (rst) last_data = 8'h00;
        if (o_rx_data_valid) begin
            obs_q.push_back(mk(cyc, 0, o_rx_data[7:0], o_rx_sof, o_frame_done));
            last_data = o_rx_data[7:0];
        end
        if (o_len_err)     obs_q.push_back(mk(cyc, 1, 8'h00, 1'b0, 1'b0));
        if (o_timeout_err) obs_q.push_back(mk(cyc, 2, 8'h00, 1'b0, 1'b0));
        if (o_ovr_err)     obs_q.push_back(mk(cyc, 3, 8'h00, 1'b0, 1'b0));
        if (!o_rx_data_valid && (o_rx_sof || o_frame_done))
            obs_q.push_back(mk(cyc, 4, 8'h00, o_rx_sof, o_frame_done));
        if (!o_rx_data_valid && o_rx_data[7:0] !== last_data)
            obs_q.push_back(mk(cyc, 5, o_rx_data[7:0], 1'b0, 1'b0));
        if (o_rx_data[31:8] !== 24'd0) obs_q.push_back(mk(cyc, 6, 8'h00, 1'b0, 1'b0));
    endtask

    // Strobe byte b so that it lands 'gap' edges after the previous strobe.
    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap - 1) tick();
        i_byte       = b;
        i_byte_valid = 1'b1;
        stim_e.push_back(cyc + 1);
        stim_b.push_back(b);
        tick();
        i_byte_valid = 1'b0;
        i_byte       = 8'($urandom);
    endtask

    task automatic send_frame(input int nsync, input int len, input int npay, input int gmin,
                              input int gmax);
        logic [15:0] l16;
        l16 = 16'(len);
        for (int i = 0; i < nsync; i++) send(8'h55, $urandom_range(gmax, gmin));
        send(8'hD5, $urandom_range(gmax, gmin));
        send(l16[7:0], $urandom_range(gmax, gmin));
        send(l16[15:8], $urandom_range(gmax, gmin));
        for (int i = 0; i < npay; i++) send(8'($urandom), $urandom_range(gmax, gmin));
    endtask

    task automatic begin_seg();
        obs_q.delete();
        stim_e.delete();
        stim_b.delete();
    endtask

    // Reference model: walks the logged input bytes as a frame parser, using edge
    // arithmetic for latencies, idle timeouts and padding, and builds exp_q.
    task automatic run_model();
        int st, s, ref_e, rem, hdr_end, pad_end, n, e, t;
        logic [7:0]  b, lo;
        logic [15:0] len;
        st = 0; s = m_sync; ref_e = 0; rem = 0; hdr_end = -1; pad_end = -1; lo = 8'h00;
        exp_q.delete();
        n = stim_e.size();
        for (int i = 0; i <= n; i++) begin
            e = (i < n) ? stim_e[i] : 32'h3fff_ffff;
            b = (i < n) ? stim_b[i] : 8'h00;
            if ((st == 1 || st == 2) && e > ref_e + TMO) begin
                push_exp(mk(ref_e + TMO, 2, 8'h00, 1'b0, 1'b0));
                st = 0;
            end
            if (st == 3 && e > ref_e + TMO) begin
                t = ref_e + TMO;
                push_exp(mk(t, 2, 8'h00, 1'b0, 1'b0));
                for (int k = 1; k <= rem; k++) push_exp(mk(t + 4 * k, 0, 8'h00, 1'b0, k == rem));
                m_frames++;
                pad_end = t + 4 * rem;
                st = 0;
            end
            if (i == n) break;
            if (e <= pad_end) continue;
            if (e <= hdr_end) begin
                push_exp(mk(e, 3, 8'h00, 1'b0, 1'b0));
                continue;
            end
            case (st)
                0: begin
                    if (b == 8'h55) begin
                        if (s < SYNC) s++;
                    end else if (b == 8'hD5 && s >= SYNC) begin
                        st = 1; ref_e = e; s = 0;
                    end else begin
                        s = 0;
                    end
                end
                1: begin
                    lo = b; st = 2; ref_e = e;
                end
                2: begin
                    len = {b, lo};
                    if (len >= 1 && len <= MAXL) begin
                        push_exp(mk(e, 0, 8'h55, 1'b1, 1'b0));
                        push_exp(mk(e + 1, 0, lo, 1'b0, 1'b0));
                        push_exp(mk(e + 2, 0, b, 1'b0, 1'b0));
                        hdr_end = e + 2; ref_e = e + 2; rem = int'(len); st = 3;
                    end else begin
                        push_exp(mk(e, 1, 8'h00, 1'b0, 1'b0));
                        st = 0;
                    end
                end
                default: begin
                    push_exp(mk(e, 0, b, 1'b0, rem == 1));
                    rem--; ref_e = e;
                    if (rem == 0) begin
                        m_frames++; st = 0;
                    end
                end
            endcase
        end
        m_sync = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({o_rx_data, o_rx_data_valid, o_rx_sof, o_frame_done, o_len_err, o_timeout_err,
                 o_ovr_err, o_frame_cnt} !== 54'd0)
                $display("FAIL reset outputs: got data=%h v=%b cnt=%h, want all zero",
                         o_rx_data, o_rx_data_valid, o_frame_cnt);
            else n_pass++;
        end
        rst = 1'b0;
        m_sync = 0; m_frames = 0;
        repeat (3) tick();
    endtask

    task automatic test_basic();
        logic [7:0] seq [8];
        seq = '{8'h55, 8'h55, 8'hD5, 8'h03, 8'h00, 8'hA1, 8'hA2, 8'hA3};
        begin_seg();
        for (int i = 0; i < 8; i++) send(seq[i], 10);
        repeat (SETTLE) tick();
        run_model();
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL basic count: got %0d, want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL basic ev%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (o_frame_cnt !== 16'd1) $display("FAIL basic frame_cnt: got %0d, want 1", o_frame_cnt);
        else n_pass++;
    endtask

    task automatic test_short_sync();
        logic [7:0] seq [11];
        seq = '{8'h55, 8'hD5, 8'h03, 8'h00, 8'h55, 8'h55, 8'hD5, 8'h02, 8'h00, 8'hB1, 8'hB2};
        begin_seg();
        for (int i = 0; i < 11; i++) send(seq[i], 6);
        repeat (SETTLE) tick();
        run_model();
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL short_sync count: got %0d, want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL short_sync ev%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (o_frame_cnt !== m_frames[15:0])
            $display("FAIL short_sync frame_cnt: got %0d, want %0d", o_frame_cnt, m_frames);
        else n_pass++;
    endtask

    task automatic test_len_err();
        begin_seg();
        send_frame(2, 0, 0, 5, 9);
        send_frame(2, MAXL + 1, 0, 5, 9);
        send_frame(3, MAXL, MAXL, 4, 7);
        repeat (SETTLE) tick();
        run_model();
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL len_err count: got %0d, want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL len_err ev%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        begin_seg();
        send_frame(2, 4, 2, 5, 8);
        repeat (SETTLE) tick();
        send_frame(2, 3, 0, 5, 8);
        send(8'h55, TMO + 1);
        send(8'hD5, 5);
        send(8'h01, TMO);
        send(8'h00, 6);
        send(8'hC3, TMO);
        repeat (SETTLE) tick();
        run_model();
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL timeout count: got %0d, want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL timeout ev%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (o_frame_cnt !== m_frames[15:0])
            $display("FAIL timeout frame_cnt: got %0d, want %0d", o_frame_cnt, m_frames);
        else n_pass++;
    endtask

    task automatic test_overrun();
        begin_seg();
        send_frame(2, 3, 0, 6, 6);
        send(8'hEE, 1);
        send(8'hA1, 4);
        send(8'hA2, 6);
        send(8'hA3, 6);
        repeat (SETTLE) tick();
        run_model();
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL overrun count: got %0d, want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL overrun ev%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        begin_seg();
        for (int f = 0; f < 4; f++) send_frame(SYNC, $urandom_range(MAXL, 1), 0, 4, 4);
        repeat (SETTLE) tick();
        run_model();
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL b2b count: got %0d, want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL b2b ev%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_full_frames();
        begin_seg();
        for (int f = 0; f < 4; f++) begin
            int l = $urandom_range(MAXL, 1);
            send_frame($urandom_range(4, 2), l, l, 4, 4);
        end
        repeat (SETTLE) tick();
        run_model();
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL full count: got %0d, want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL full ev%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (o_frame_cnt !== m_frames[15:0])
            $display("FAIL full frame_cnt: got %0d, want %0d", o_frame_cnt, m_frames);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 4; seg++) begin
            begin_seg();
            for (int k = 0; k < 8; k++) begin
                int kind = $urandom_range(4, 0);
                int l = $urandom_range(MAXL, 2);
                case (kind)
                    0: send_frame($urandom_range(4, 2), l, l, 4, 10);
                    1: send_frame(2, l, $urandom_range(l - 1, 0), 4, 10);
                    2: send_frame(2, ($urandom_range(1, 0) != 0) ? 0 : MAXL + 1 + $urandom_range(200, 0),
                                  0, 4, 10);
                    3: for (int j = 0; j < 3; j++) send(8'($urandom), $urandom_range(10, 4));
                    default: send_frame(1, 3, 0, 4, 10);
                endcase
            end
            repeat (SETTLE) tick();
            run_model();
            n_total++;
            if (obs_q.size() != exp_q.size())
                $display("FAIL random%0d count: got %0d, want %0d", seg, obs_q.size(), exp_q.size());
            else n_pass++;
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                n_total++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL random%0d ev%0d: got %h, want %h", seg, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
            n_total++;
            if (o_frame_cnt !== m_frames[15:0])
                $display("FAIL random%0d frame_cnt: got %0d, want %0d", seg, o_frame_cnt, m_frames);
            else n_pass++;
        end
    endtask

    task automatic test_reset_midframe();
        begin_seg();
        send_frame(2, 6, 2, 5, 5);
        repeat (2) tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if ({o_rx_data, o_rx_data_valid, o_rx_sof, o_frame_done, o_len_err, o_timeout_err,
                 o_ovr_err, o_frame_cnt} !== 54'd0)
                $display("FAIL midreset outputs: got data=%h v=%b cnt=%h, want all zero",
                         o_rx_data, o_rx_data_valid, o_frame_cnt);
            else n_pass++;
        end
        rst = 1'b0;
        m_sync = 0; m_frames = 0;
        // Sync gathered before a reset must not survive it.
        send(8'h55, 5);
        send(8'h55, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        begin_seg();
        send(8'hD5, 5);
        send(8'h03, 5);
        send(8'h00, 5);
        send_frame(2, 5, 5, 4, 8);
        repeat (SETTLE) tick();
        run_model();
        n_total++;
        if (obs_q.size() != exp_q.size())
            $display("FAIL midreset count: got %0d, want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_total++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL midreset ev%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (o_frame_cnt !== 16'd1)
            $display("FAIL midreset frame_cnt: got %0d, want 1", o_frame_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short_sync();
        test_len_err();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_full_frames();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
